// File: rtl/a2bus_event_fifo.sv
// Apple II bus event capture FIFO.
// Qualifies strobed bus cycles against an address window and queues matching
// cycles as {addr, data, rw_n} events in a first-word-fall-through FIFO.
// Overflow drops are flagged (sticky) and counted with saturation.
module a2bus_event_fifo #(
  parameter int unsigned DEPTH         = 16,
  parameter logic [15:0] ADDR_LO       = 16'h0400,
  parameter logic [15:0] ADDR_HI       = 16'h0BFF,
  parameter bit          CAPTURE_READS = 1'b0
) (
  input  logic                       clk_logic_i,
  input  logic                       system_reset_n_i,
  input  logic                       enable_i,
  input  logic [15:0]                addr_i,
  input  logic [7:0]                 data_i,
  input  logic                       rw_n_i,
  input  logic                       data_in_strobe_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [15:0]                evt_addr_o,
  output logic [7:0]                 evt_data_o,
  output logic                       evt_rw_n_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_count_o,
  input  logic                       clear_overflow_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 25;

  logic [EW-1:0] mem_q [DEPTH];

  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_count_q, drop_count_d;

  logic          match;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] head;

  // Qualify the bus cycle and decide push/pop/drop for this clock.
  always_comb begin
    match = data_in_strobe_i && enable_i && (addr_i >= ADDR_LO) && (addr_i <= ADDR_HI) &&
            (!rw_n_i || CAPTURE_READS);
    full  = (level_q == LW'(DEPTH));
    empty = (level_q == '0);
    pop   = !empty && evt_ready_i;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    push  = match && (!full || pop);
    drop  = match && full && !pop;
  end

  // Next-state for pointers, occupancy and overflow bookkeeping.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) wr_ptr_d = wr_ptr_q + LW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + LW'(1);
    level_d = level_q + LW'(push) - LW'(pop);

    // A drop coinciding with a clear wins: the count restarts at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_overflow_i) begin
        drop_count_d = 8'd1;
      end else if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end else if (clear_overflow_i) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Event storage; contents need no reset since outputs are gated by valid.
  always_ff @(posedge clk_logic_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {addr_i, data_i, rw_n_i};
  end

  // Head presentation: fall-through from storage, forced to zero when empty.
  always_comb begin
    head = mem_q[rd_ptr_q[AW-1:0]];
    if (empty) head = '0;
    evt_valid_o  = !empty;
    evt_addr_o   = head[24:9];
    evt_data_o   = head[8:1];
    evt_rw_n_o   = head[0];
    level_o      = level_q;
    overflow_o   = overflow_q;
    drop_count_o = drop_count_q;
  end

endmodule

// File: tb/tb_a2bus_event_fifo.sv
// Self-checking bench for a2bus_event_fifo (DEPTH=16, window 0400..0BFF, writes only).
module tb_a2bus_event_fifo;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        rw_n;
  logic        strobe;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_addr;
  logic [7:0]  evt_data;
  logic        evt_rw_n;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clear_ovf;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [24:0] mq[$];
  logic        m_ovf;
  int          m_cnt;

  a2bus_event_fifo #(
    .DEPTH(16), .ADDR_LO(16'h0400), .ADDR_HI(16'h0BFF), .CAPTURE_READS(1'b0)
  ) dut (
    .clk_logic_i     (clk),
    .system_reset_n_i(rst_n),
    .enable_i        (enable),
    .addr_i          (addr),
    .data_i          (data),
    .rw_n_i          (rw_n),
    .data_in_strobe_i(strobe),
    .evt_valid_o     (evt_valid),
    .evt_ready_i     (evt_ready),
    .evt_addr_o      (evt_addr),
    .evt_data_o      (evt_data),
    .evt_rw_n_o      (evt_rw_n),
    .level_o         (level),
    .overflow_o      (overflow),
    .drop_count_o    (drop_count),
    .clear_overflow_i(clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_state(input string name);
    logic [24:0] exp_head;
    exp_head = (mq.size() > 0) ? mq[0] : 25'd0;
    check({name, ".level"}, 32'(level), 32'(mq.size()));
    check({name, ".valid"}, 32'(evt_valid), 32'(mq.size() > 0));
    check({name, ".head"}, 32'({evt_addr, evt_data, evt_rw_n}), 32'(exp_head));
    check({name, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({name, ".drops"}, 32'(drop_count), 32'(m_cnt));
  endtask

  // One clock: apply inputs, advance the model, then check after the edge.
  task automatic cycle(input string name, input logic stb, input logic [15:0] a,
                       input logic [7:0] d, input logic rw, input logic en,
                       input logic rdy, input logic clr);
    bit m, full, pop;
    logic [24:0] tmp;
    strobe = stb; addr = a; data = d; rw_n = rw; enable = en;
    evt_ready = rdy; clear_ovf = clr;
    m    = stb && en && (a >= 16'h0400) && (a <= 16'h0BFF) && !rw;
    full = (mq.size() == 16);
    pop  = rdy && (mq.size() > 0);
    if (pop) tmp = mq.pop_front();
    if (m && (!full || pop)) mq.push_back({a, d, rw});
    if (m && full && !pop) begin
      m_ovf = 1'b1;
      m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    strobe = 1'b0; evt_ready = 1'b0; clear_ovf = 1'b0;
    check_state(name);
  endtask

  task automatic push_w(input string name, input logic [15:0] a, input logic [7:0] d);
    cycle(name, 1'b1, a, d, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_one(input string name);
    cycle(name, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic        en;
    int          exp_level;
  } vec_t;

  vec_t vt[7];

  initial begin
    rst_n = 1'b0; enable = 1'b0; addr = '0; data = '0; rw_n = 1'b1;
    strobe = 1'b0; evt_ready = 1'b0; clear_ovf = 1'b0;
    m_ovf = 1'b0; m_cnt = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Qualification table: window edges, out-of-window, reads, disabled
    vt[0] = '{16'h0400, 8'hA1, 1'b0, 1'b1, 1};
    vt[1] = '{16'h07FF, 8'hB2, 1'b0, 1'b1, 2};
    vt[2] = '{16'h0BFF, 8'hC3, 1'b0, 1'b1, 3};
    vt[3] = '{16'h03FF, 8'h11, 1'b0, 1'b1, 3};
    vt[4] = '{16'h0C00, 8'h22, 1'b0, 1'b1, 3};
    vt[5] = '{16'h0500, 8'h33, 1'b1, 1'b1, 3};
    vt[6] = '{16'h0500, 8'h44, 1'b0, 1'b0, 3};
    for (int i = 0; i < 7; i++) begin
      cycle($sformatf("vec%0d", i), 1'b1, vt[i].addr, vt[i].data, vt[i].rw_n, vt[i].en,
            1'b0, 1'b0);
      check($sformatf("vec%0d.lvl_tab", i), 32'(level), 32'(vt[i].exp_level));
    end
    check("head0400", 32'({evt_addr, evt_data, evt_rw_n}), 32'({16'h0400, 8'hA1, 1'b0}));
    for (int i = 0; i < 3; i++) pop_one($sformatf("drain1_%0d", i));
    check("drain1.empty", 32'(level), 32'd0);

    // Overflow: 18 writes into a 16-deep FIFO
    for (int i = 0; i < 18; i++) push_w($sformatf("fill%0d", i), 16'h0600 + 16'(i), 8'(i));
    check("ovf18.level", 32'(level), 32'd16);
    check("ovf18.ovf", 32'(overflow), 32'd1);
    check("ovf18.drops", 32'(drop_count), 32'd2);
    for (int i = 0; i < 16; i++) pop_one($sformatf("drain2_%0d", i));
    cycle("clear", 1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("clear.drops", 32'(drop_count), 32'd0);

    // Push coincident with pop while full: no drop, new event at tail
    for (int i = 0; i < 16; i++) push_w($sformatf("fill3_%0d", i), 16'h0800 + 16'(i), 8'h50);
    cycle("pushpop", 1'b1, 16'h0AAA, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
    check("pushpop.level", 32'(level), 32'd16);
    check("pushpop.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) pop_one($sformatf("drain3_%0d", i));

    // Drop-count saturation, then clear coinciding with a drop
    for (int i = 0; i < 16; i++) push_w($sformatf("fill4_%0d", i), 16'h0900 + 16'(i), 8'h60);
    for (int i = 0; i < 300; i++) push_w("drop", 16'h0444, 8'h77);
    check("sat.drops", 32'(drop_count), 32'd255);
    cycle("clrdrop", 1'b1, 16'h0444, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
    check("clrdrop.drops", 32'(drop_count), 32'd1);
    check("clrdrop.ovf", 32'(overflow), 32'd1);

    // Asynchronous reset mid-stream at level 5
    for (int i = 0; i < 11; i++) pop_one($sformatf("drain4_%0d", i));
    check("prerst.level", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.valid", 32'(evt_valid), 32'd0);
    check("rst.level", 32'(level), 32'd0);
    check("rst.ovf", 32'(overflow), 32'd0);
    check("rst.drops", 32'(drop_count), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_w("postrst", 16'h0BCD, 8'hEE);
    check("postrst.valid", 32'(evt_valid), 32'd1);
    check("postrst.head", 32'({evt_addr, evt_data, evt_rw_n}), 32'({16'h0BCD, 8'hEE, 1'b0}));
    pop_one("postrst.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
